// File: rtl/stream_pattern_source.sv
// Valid/ready stream source emitting one or more bursts of incrementing data per start pulse.
// Define STREAM_SOURCE_GAP_EN to add the StGap state and gap counter for idle cycles between bursts.
`timescale 1ns/1ps

module stream_pattern_source #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned LEN_SIZE  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_clk_ni,
    input  logic                 start_i,
    input  logic [LEN_SIZE-1:0]  burst_len_i,
    input  logic [LEN_SIZE-1:0]  bursts_i,
    input  logic [DATA_SIZE-1:0] seed_i,
    input  logic [LEN_SIZE-1:0]  gap_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 data_last_o,
    input  logic                 data_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {
`ifdef STREAM_SOURCE_GAP_EN
        StGap  = 2'd2,
`endif
        StIdle = 2'd0,
        StSend = 2'd1
    } state_e;

    state_e               r_state,     w_state_nxt;
    logic [DATA_SIZE-1:0] r_data,      w_data_nxt;
    logic [LEN_SIZE-1:0]  r_len,       w_len_nxt;
    logic [LEN_SIZE-1:0]  r_bursts,    w_bursts_nxt;
    logic [LEN_SIZE-1:0]  r_beat_cnt,  w_beat_nxt;
    logic [LEN_SIZE-1:0]  r_burst_cnt, w_burst_nxt;
    logic                 r_valid,     w_valid_nxt;
    logic                 r_last,      w_last_nxt;
    logic                 r_busy,      w_busy_nxt;
    logic                 r_done,      w_done_nxt;
`ifdef STREAM_SOURCE_GAP_EN
    logic [LEN_SIZE-1:0]  r_gap,       w_gap_nxt;
    logic [LEN_SIZE-1:0]  r_gap_cnt,   w_gap_cnt_nxt;
`else
    logic                 w_unused_gap;
    assign w_unused_gap = ^gap_i;
`endif

    logic w_hs;
    logic w_last_beat;
    logic w_final_burst;

    // r_valid mirrors StSend, so the handshake never loops ready back into valid.
    assign w_hs          = r_valid & data_ready_i;
    assign w_last_beat   = (r_beat_cnt == r_len - LEN_SIZE'(1));
    assign w_final_burst = (r_burst_cnt == r_bursts - LEN_SIZE'(1));

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_len_nxt     = r_len;
        w_bursts_nxt  = r_bursts;
        w_beat_nxt    = r_beat_cnt;
        w_burst_nxt   = r_burst_cnt;
        w_done_nxt    = 1'b0;
`ifdef STREAM_SOURCE_GAP_EN
        w_gap_nxt     = r_gap;
        w_gap_cnt_nxt = r_gap_cnt;
`endif
        case (r_state)
            StIdle: begin
                if (start_i && (burst_len_i != '0) && (bursts_i != '0)) begin
                    w_state_nxt  = StSend;
                    w_data_nxt   = seed_i;
                    w_len_nxt    = burst_len_i;
                    w_bursts_nxt = bursts_i;
                    w_beat_nxt   = '0;
                    w_burst_nxt  = '0;
`ifdef STREAM_SOURCE_GAP_EN
                    w_gap_nxt     = gap_i;
                    w_gap_cnt_nxt = '0;
`endif
                end
            end
            StSend: begin
                if (w_hs) begin
                    w_data_nxt = r_data + DATA_SIZE'(1);
                    if (w_last_beat) begin
                        w_beat_nxt = '0;
                        if (w_final_burst) begin
                            w_state_nxt = StIdle;
                            w_burst_nxt = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_burst_nxt = r_burst_cnt + LEN_SIZE'(1);
`ifdef STREAM_SOURCE_GAP_EN
                            if (r_gap != '0) begin
                                w_state_nxt   = StGap;
                                w_gap_cnt_nxt = '0;
                            end
`endif
                        end
                    end else begin
                        w_beat_nxt = r_beat_cnt + LEN_SIZE'(1);
                    end
                end
            end
`ifdef STREAM_SOURCE_GAP_EN
            StGap: begin
                if (r_gap_cnt == r_gap - LEN_SIZE'(1)) begin
                    w_state_nxt   = StSend;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + LEN_SIZE'(1);
                end
            end
`endif
            default: w_state_nxt = StIdle;
        endcase

        // Outputs are computed from next state so they can be registered without a cycle of lag.
        w_valid_nxt = (w_state_nxt == StSend);
        w_last_nxt  = w_valid_nxt && (w_beat_nxt == w_len_nxt - LEN_SIZE'(1));
        w_busy_nxt  = (w_state_nxt != StIdle);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_clk_ni) begin
        if (!rst_clk_ni) begin
            r_state     <= StIdle;
            r_data      <= '0;
            r_len       <= '0;
            r_bursts    <= '0;
            r_beat_cnt  <= '0;
            r_burst_cnt <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef STREAM_SOURCE_GAP_EN
            r_gap       <= '0;
            r_gap_cnt   <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_data      <= w_data_nxt;
            r_len       <= w_len_nxt;
            r_bursts    <= w_bursts_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_valid     <= w_valid_nxt;
            r_last      <= w_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
`ifdef STREAM_SOURCE_GAP_EN
            r_gap       <= w_gap_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
`endif
        end
    end

    assign data_o       = r_data;
    assign data_valid_o = r_valid;
    assign data_last_o  = r_last;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule

// File: tb/tb_stream_pattern_source.sv
// Self-checking bench for stream_pattern_source: directed scenarios plus randomized sequences
// checked against a beat-index model; gap expectations follow STREAM_SOURCE_GAP_EN.
`timescale 1ns/1ps

module tb_stream_pattern_source;

    logic       clk_i = 1'b0;
    logic       rst_clk_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] burst_len_i = '0;
    logic [7:0] bursts_i = '0;
    logic [7:0] seed_i = '0;
    logic [7:0] gap_i = '0;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       data_last_o;
    logic       data_ready_i = 1'b1;
    logic       busy_o;
    logic       done_o;

    int n_checks = 0;
    int n_errors = 0;

    // Fields of the sequence currently expected from the DUT.
    int         m_len, m_bursts, m_gap;
    logic [7:0] m_seed;

    stream_pattern_source #(.DATA_SIZE(8), .LEN_SIZE(8)) dut (
        .clk_i        (clk_i),
        .rst_clk_ni   (rst_clk_ni),
        .start_i      (start_i),
        .burst_len_i  (burst_len_i),
        .bursts_i     (bursts_i),
        .seed_i       (seed_i),
        .gap_i        (gap_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_last_o  (data_last_o),
        .data_ready_i (data_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(data_valid_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o),       32'd0);
        check({tag, "_done"},  32'(done_o),       32'd0);
    endtask

    // Called at a negedge: presents a start request for the next rising edge.
    task automatic start_seq(input logic [7:0] seed, input int len, input int bursts, input int gap);
        m_seed = seed; m_len = len; m_bursts = bursts; m_gap = gap;
        seed_i = seed; burst_len_i = 8'(len); bursts_i = 8'(bursts); gap_i = 8'(gap);
        start_i = 1'b1;
    endtask

    // Walks the expected beat stream index by index. Ready modes: 0 always, 1 random,
    // 2 stall three cycles on beat 1. Returns at the negedge showing done_o.
    task automatic run_seq(input int mode, input bit mid_start);
        int idx = 0;
        int gap_left = 0;
        int stalls = 0;
        int cyc = 0;
        int total = m_len * m_bursts;
        int g;
        bit exp_v;
        logic rdy;
        logic [7:0] exp_d;
`ifdef STREAM_SOURCE_GAP_EN
        g = m_gap;
`else
        g = 0;
`endif
        @(negedge clk_i);
        start_i = 1'b0;
        while (idx < total) begin
            if (cyc > 2000) begin
                check("seq_timeout", 32'(idx), 32'(total));
                return;
            end
            exp_v = (gap_left == 0);
            check("valid", 32'(data_valid_o), 32'(exp_v));
            check("busy",  32'(busy_o), 32'd1);
            check("done_mid", 32'(done_o), 32'd0);
            if (exp_v) begin
                exp_d = m_seed + 8'(idx);
                check("data", 32'(data_o), 32'(exp_d));
                check("last", 32'(data_last_o), 32'((idx % m_len) == m_len - 1));
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    rdy = !(exp_v && idx == 1 && stalls < 3);
                    if (!rdy) stalls++;
                end
            endcase
            data_ready_i = rdy;
            if (mid_start && cyc == 2) begin
                start_i = 1'b1;
                seed_i = 8'($urandom); burst_len_i = 8'($urandom_range(1, 9));
                bursts_i = 8'($urandom_range(1, 9)); gap_i = 8'($urandom_range(0, 3));
            end else begin
                start_i = 1'b0;
            end
            if (exp_v && rdy) begin
                idx++;
                if ((idx % m_len) == 0 && idx < total) gap_left = g;
            end else if (!exp_v) begin
                gap_left--;
            end
            cyc++;
            @(negedge clk_i);
        end
        start_i = 1'b0;
        check("done_pulse", 32'(done_o), 32'd1);
        check("done_busy",  32'(busy_o), 32'd0);
        check("done_valid", 32'(data_valid_o), 32'd0);
    endtask

    initial begin
        // Reset state.
        #1;
        check("rst_data",  32'(data_o), 32'd0);
        check("rst_last",  32'(data_last_o), 32'd0);
        check_idle("rst");
        @(negedge clk_i);
        rst_clk_ni = 1'b1;
        @(negedge clk_i);
        check_idle("post_rst");

        // Basic with wrap, then a start in the done cycle launches the backpressure run.
        start_seq(8'hFE, 4, 1, 0);
        run_seq(0, 1'b0);
        start_seq(8'hFE, 4, 1, 0);
        run_seq(2, 1'b0);
        @(negedge clk_i);
        check_idle("after_bp");

        // Multi-burst with gap request.
        start_seq(8'h00, 2, 3, 2);
        run_seq(0, 1'b0);
        @(negedge clk_i);
        check_idle("after_multi");

        // Ignored starts: zero length, then zero bursts.
        start_i = 1'b1; burst_len_i = 8'd0; bursts_i = 8'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        check_idle("len0_a");
        @(negedge clk_i);
        check_idle("len0_b");
        start_i = 1'b1; burst_len_i = 8'd3; bursts_i = 8'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        check_idle("bursts0_a");
        @(negedge clk_i);
        check_idle("bursts0_b");

        // Mid-burst start is ignored.
        start_seq(8'h40, 5, 2, 1);
        run_seq(1, 1'b1);
        @(negedge clk_i);
        check_idle("after_mid");

        // Randomized sequences.
        for (int i = 0; i < 8; i++) begin
            start_seq(8'($urandom), $urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(0, 3));
            run_seq(1, i[0]);
            @(negedge clk_i);
            check_idle("after_rand");
        end

        // Asynchronous reset during a stalled last beat.
        start_seq(8'h5A, 1, 2, 0);
        @(negedge clk_i);
        start_i = 1'b0;
        data_ready_i = 1'b0;
        check("ar_valid_pre", 32'(data_valid_o), 32'd1);
        check("ar_last_pre",  32'(data_last_o), 32'd1);
        check("ar_data_pre",  32'(data_o), 32'h5A);
        #2 rst_clk_ni = 1'b0;
        #1;
        check("ar_valid", 32'(data_valid_o), 32'd0);
        check("ar_last",  32'(data_last_o), 32'd0);
        check("ar_busy",  32'(busy_o), 32'd0);
        check("ar_data",  32'(data_o), 32'd0);
        @(negedge clk_i);
        rst_clk_ni = 1'b1;
        data_ready_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            check_idle("ar_post");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_pattern_source.md
# stream_pattern_source

Valid/ready stream transmitter producing programmable bursts of incrementing data for driving skid buffers, FIFOs and other stream sinks in block-level and on-chip self-test setups. A single start pulse launches a sequence of one or more bursts. The output fully obeys valid/ready backpressure: payload stays stable while stalled. Optional idle gaps can be inserted between bursts.

## Interface
- DATA_SIZE, 8, data beat width in bits
- LEN_SIZE, 8, width of the burst length, burst count and gap fields
- clk_i  in  1  clock, all logic on rising edge
- rst_clk_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  launch request, sampled only in StIdle
- burst_len_i  in  LEN_SIZE  beats per burst, latched at start
- bursts_i  in  LEN_SIZE  number of bursts, latched at start
- seed_i  in  DATA_SIZE  first beat value, latched at start
- gap_i  in  LEN_SIZE  idle cycles between bursts, latched at start; ignored unless STREAM_SOURCE_GAP_EN
- data_o  out  DATA_SIZE  beat payload
- data_valid_o  out  1  beat valid
- data_last_o  out  1  final beat of current burst
- data_ready_i  in  1  sink ready
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse, sequence complete

## Operation
- States: StIdle, StSend, StGap (StGap exists only with the macro).
- StIdle -> StSend: start_i=1, burst_len_i!=0 and bursts_i!=0. Latch all fields. Load data register with seed_i. Clear beat and burst counters.
- start_i with burst_len_i=0 or bursts_i=0: ignored. Stay in StIdle, no done_o.
- start_i outside StIdle: ignored.
- StSend: data_valid_o=1 continuously.
- Handshake = data_valid_o & data_ready_i. Each handshake increments data modulo 2^DATA_SIZE (wraps, no saturation) and increments the beat counter.
- Data sequence is continuous across bursts; it does not restart at the seed for each burst.
- data_last_o=1 while beat counter == latched burst_len-1.
- Handshake on last beat, bursts remaining: go to StGap if the macro is enabled and gap!=0, else stay in StSend. Beat counter clears, burst counter increments.
- Handshake on last beat of final burst: go to StIdle, pulse done_o.
- StGap: data_valid_o=0. Count latched gap cycles, then return to StSend.
- Stability: while data_valid_o=1 and data_ready_i=0, data_o, data_last_o and data_valid_o hold unchanged.
- data_valid_o never depends combinationally on data_ready_i.
- busy_o=1 in StSend and StGap.
- Counters are LEN_SIZE bits wide; the maximum burst length and burst count are 2^LEN_SIZE-1.

## Timing
- Reset values: data_o=0, data_valid_o=0, data_last_o=0, busy_o=0, done_o=0, state StIdle, all counters 0.
- Reset assertion clears every output immediately, with no clock edge, including mid-burst. The sequence is abandoned.
- After reset deassertion, no beat is produced until a new start_i.
- Start latency: start_i sampled at edge N gives data_valid_o=1, data_o=seed, busy_o=1 after edge N.
- Throughput: one beat per cycle while data_ready_i=1. Back-to-back across bursts when there is no gap.
- Gap: exactly gap cycles with data_valid_o=0 between the last-beat handshake and the next valid beat.
- done_o is high for the single cycle after the final handshake, with busy_o=0 in that cycle. start_i is accepted in that same cycle.
- All outputs are registered.

## Configuration
- STREAM_SOURCE_GAP_EN defined: StGap and the gap counter are present; gap_i inserts idle cycles between bursts.
- STREAM_SOURCE_GAP_EN undefined: no StGap, no gap counter, gap_i unused. Bursts are always back-to-back, the same behaviour as gap_i=0 with the macro enabled.

## Test plan
- Basic with wrap: seed=8'hFE, len=4, bursts=1, ready held 1.
  - Valid for 4 cycles, data FE,FF,00,01.
  - Last only on 01.
  - done_o pulse the next cycle, then valid=0.
- Backpressure: same setup, ready=0 for 3 cycles while beat FF is presented.
  - data_o=FF, valid=1 and last=0 held all 3 cycles.
  - Sequence resumes FF,00,01; 4 beats total, no duplicates.
- Multi-burst, macro on: seed=0, len=2, bursts=3, gap=2, ready=1.
  - Valid pattern 1,1,0,0,1,1,0,0,1,1.
  - Data 0..5, last on data 1, 3 and 5.
  - Same stimulus with macro off: 6 consecutive valid beats with the same data and last positions.
- Ignored starts: start with len=0, then bursts=0 → no valid and no done.
  - start_i pulsed mid-burst → sequence unaffected.
  - start_i in the done_o cycle → new sequence begins the next cycle.
- Async reset: assert rst_clk_ni between clock edges during a stalled beat.
  - valid, last, busy and data go to 0 before the next edge.
  - After release, outputs stay idle until start_i.
